// File: rtl/prl_rx_pe_dispatch.sv
// Buffers PRL RX message notifications in a small FIFO and presents them to the
// policy engine over a valid/ack handshake, with Soft_Reset replace and flush.
module prl_rx_pe_dispatch #(
  parameter int         DEPTH           = 4,
  parameter logic [6:0] SOFT_RESET_TYPE = 7'h0D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pl2pe_rx_en,
  input  logic [6:0]               pl2pe_rx_type,
  input  logic [2:0]               pl2pe_rx_sop_type,
  input  logic [22:0]              pl2pe_rx_info,
  output logic                     pe_rx_vld,
  output logic [6:0]               pe_rx_type,
  output logic [2:0]               pe_rx_sop_type,
  output logic [22:0]              pe_rx_info,
  input  logic                     pe_rx_ack,
  input  logic                     pe_rx_flush,
  output logic                     rx_ovf,
  input  logic                     rx_ovf_clr,
  output logic [7:0]               rx_drop_cnt,
  output logic [$clog2(DEPTH):0]   rx_q_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [32:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          ovf_r;
  logic [7:0]    drop_cnt_r;

  logic [32:0]   entry_s;
  logic          sr_s, push_s, pop_s, full_s, push_ok_s, drop_s, wr_en_s;
  logic [AW-1:0] wr_idx_s, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          ovf_nxt_s;
  logic [7:0]    drop_cnt_nxt_s;

  assign entry_s = {pl2pe_rx_type, pl2pe_rx_sop_type, pl2pe_rx_info};
  assign sr_s    = pl2pe_rx_en && (pl2pe_rx_type == SOFT_RESET_TYPE);
  assign push_s  = pl2pe_rx_en && (pl2pe_rx_type != SOFT_RESET_TYPE);
  assign pop_s   = pe_rx_ack && (cnt_r != CNT_ZERO);
  assign full_s  = (cnt_r == CNT_FULL);
  // A flushed push is simply discarded; only a genuine full-queue push is a drop.
  assign drop_s  = push_s && full_s && !pop_s && !pe_rx_flush;

  // Queue next-state: flush beats Soft_Reset, which beats normal push/pop.
  always_comb begin
    wr_en_s      = 1'b0;
    wr_idx_s     = wr_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    cnt_nxt_s    = cnt_r;
    push_ok_s    = 1'b0;
    if (pe_rx_flush) begin
      wr_ptr_nxt_s = PTR_ZERO;
      rd_ptr_nxt_s = PTR_ZERO;
      cnt_nxt_s    = CNT_ZERO;
    end else if (sr_s) begin
      wr_en_s      = 1'b1;
      wr_idx_s     = PTR_ZERO;
      rd_ptr_nxt_s = PTR_ZERO;
      wr_ptr_nxt_s = PTR_ONE;
      cnt_nxt_s    = CNT_ONE;
    end else begin
      push_ok_s = push_s && (!full_s || pop_s);
      if (push_ok_s) begin
        wr_en_s      = 1'b1;
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_s})
        2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
        2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  // Overflow status: a same-cycle drop wins over clear and restarts the count at 1.
  always_comb begin
    ovf_nxt_s      = ovf_r;
    drop_cnt_nxt_s = drop_cnt_r;
    if (drop_s) begin
      ovf_nxt_s = 1'b1;
      if (rx_ovf_clr) begin
        drop_cnt_nxt_s = 8'd1;
      end else if (drop_cnt_r != 8'hFF) begin
        drop_cnt_nxt_s = drop_cnt_r + 8'd1;
      end else begin
        drop_cnt_nxt_s = drop_cnt_r;
      end
    end else if (rx_ovf_clr) begin
      ovf_nxt_s      = 1'b0;
      drop_cnt_nxt_s = 8'd0;
    end else begin
      ovf_nxt_s      = ovf_r;
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {33{1'b0}};
      end
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      cnt_r      <= CNT_ZERO;
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_idx_s] <= entry_s;
      end
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ovf_r      <= ovf_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  assign pe_rx_vld      = (cnt_r != CNT_ZERO);
  assign pe_rx_type     = mem_r[rd_ptr_r][32:26];
  assign pe_rx_sop_type = mem_r[rd_ptr_r][25:23];
  assign pe_rx_info     = mem_r[rd_ptr_r][22:0];
  assign rx_ovf         = ovf_r;
  assign rx_drop_cnt    = drop_cnt_r;
  assign rx_q_cnt       = cnt_r;

endmodule

// File: tb/tb_prl_rx_pe_dispatch.sv
// Directed self-checking bench for prl_rx_pe_dispatch (DEPTH = 4).
module tb_prl_rx_pe_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pl2pe_rx_en;
  logic [6:0]  pl2pe_rx_type;
  logic [2:0]  pl2pe_rx_sop_type;
  logic [22:0] pl2pe_rx_info;
  logic        pe_rx_vld;
  logic [6:0]  pe_rx_type;
  logic [2:0]  pe_rx_sop_type;
  logic [22:0] pe_rx_info;
  logic        pe_rx_ack;
  logic        pe_rx_flush;
  logic        rx_ovf;
  logic        rx_ovf_clr;
  logic [7:0]  rx_drop_cnt;
  logic [2:0]  rx_q_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  prl_rx_pe_dispatch #(.DEPTH(4), .SOFT_RESET_TYPE(7'h0D)) dut (
    .clk(clk), .rst(rst),
    .pl2pe_rx_en(pl2pe_rx_en), .pl2pe_rx_type(pl2pe_rx_type),
    .pl2pe_rx_sop_type(pl2pe_rx_sop_type), .pl2pe_rx_info(pl2pe_rx_info),
    .pe_rx_vld(pe_rx_vld), .pe_rx_type(pe_rx_type),
    .pe_rx_sop_type(pe_rx_sop_type), .pe_rx_info(pe_rx_info),
    .pe_rx_ack(pe_rx_ack), .pe_rx_flush(pe_rx_flush),
    .rx_ovf(rx_ovf), .rx_ovf_clr(rx_ovf_clr),
    .rx_drop_cnt(rx_drop_cnt), .rx_q_cnt(rx_q_cnt)
  );

  always #5 clk = ~clk;

  // Inputs are set before step and observed #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pl2pe_rx_en = 1'b0; pl2pe_rx_type = 7'h00; pl2pe_rx_sop_type = 3'h0;
    pl2pe_rx_info = 23'h0; pe_rx_ack = 1'b0; pe_rx_flush = 1'b0; rx_ovf_clr = 1'b0;
  endtask

  task automatic push(input logic [6:0] t, input logic [2:0] s, input logic [22:0] i);
    pl2pe_rx_en = 1'b1; pl2pe_rx_type = t; pl2pe_rx_sop_type = s; pl2pe_rx_info = i;
    step();
    idle();
  endtask

  task automatic ack();
    pe_rx_ack = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_tests++;
    if ({pe_rx_vld, rx_q_cnt, rx_ovf, rx_drop_cnt} !== 13'h0) begin
      n_fail++; $display("FAIL reset_status: got vld=%b cnt=%0d ovf=%b drop=%0d exp all 0", pe_rx_vld, rx_q_cnt, rx_ovf, rx_drop_cnt);
    end
    n_tests++;
    if ({pe_rx_type, pe_rx_sop_type, pe_rx_info} !== 33'h0) begin
      n_fail++; $display("FAIL reset_head: got %h exp 0", {pe_rx_type, pe_rx_sop_type, pe_rx_info});
    end
  endtask

  task automatic test_single();
    push(7'h01, 3'h0, 23'h12345);
    n_tests++;
    if ({pe_rx_vld, pe_rx_type, pe_rx_sop_type, pe_rx_info, rx_q_cnt} !== {1'b1, 7'h01, 3'h0, 23'h12345, 3'd1}) begin
      n_fail++; $display("FAIL single_head: got vld=%b type=%h sop=%h info=%h cnt=%0d exp 1/01/0/12345/1", pe_rx_vld, pe_rx_type, pe_rx_sop_type, pe_rx_info, rx_q_cnt);
    end
    ack();
    n_tests++;
    if (pe_rx_vld !== 1'b0 || rx_q_cnt !== 3'd0) begin
      n_fail++; $display("FAIL single_ack: got vld=%b cnt=%0d exp 0/0", pe_rx_vld, rx_q_cnt);
    end
  endtask

  task automatic test_burst_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 4; k++) push(7'h01, 3'(r), 23'(k + 16 * r));
      n_tests++;
      if (rx_q_cnt !== 3'd4) begin
        n_fail++; $display("FAIL burst_cnt round %0d: got %0d exp 4", r, rx_q_cnt);
      end
      for (int k = 1; k <= 4; k++) begin
        n_tests++;
        if (pe_rx_vld !== 1'b1 || pe_rx_info !== 23'(k + 16 * r) || pe_rx_sop_type !== 3'(r)) begin
          n_fail++; $display("FAIL burst_order round %0d: got vld=%b info=%h exp 1/%h", r, pe_rx_vld, pe_rx_info, k + 16 * r);
        end
        ack();
      end
      n_tests++;
      if (pe_rx_vld !== 1'b0) begin
        n_fail++; $display("FAIL burst_drain round %0d: got vld=%b exp 0", r, pe_rx_vld);
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 4; k++) push(7'h01, 3'h1, 23'(k));
    for (int k = 0; k < 3; k++) push(7'h01, 3'h1, 23'h100 + 23'(k));
    n_tests++;
    if (rx_ovf !== 1'b1 || rx_drop_cnt !== 8'd3 || rx_q_cnt !== 3'd4 || pe_rx_info !== 23'd1) begin
      n_fail++; $display("FAIL ovf_drop: got ovf=%b drop=%0d cnt=%0d head=%h exp 1/3/4/1", rx_ovf, rx_drop_cnt, rx_q_cnt, pe_rx_info);
    end
    pe_rx_ack = 1'b1;
    push(7'h01, 3'h1, 23'd5);
    n_tests++;
    if (rx_drop_cnt !== 8'd3 || rx_q_cnt !== 3'd4) begin
      n_fail++; $display("FAIL ovf_push_pop: got drop=%0d cnt=%0d exp 3/4", rx_drop_cnt, rx_q_cnt);
    end
    for (int k = 2; k <= 5; k++) begin
      n_tests++;
      if (pe_rx_info !== 23'(k)) begin
        n_fail++; $display("FAIL ovf_order: got %h exp %h", pe_rx_info, k);
      end
      ack();
    end
    rx_ovf_clr = 1'b1; step(); idle();
    n_tests++;
    if (rx_ovf !== 1'b0 || rx_drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL ovf_clr: got ovf=%b drop=%0d exp 0/0", rx_ovf, rx_drop_cnt);
    end
    for (int k = 1; k <= 4; k++) push(7'h01, 3'h0, 23'(k));
    push(7'h01, 3'h0, 23'h9);
    push(7'h01, 3'h0, 23'h9);
    rx_ovf_clr = 1'b1;
    push(7'h01, 3'h0, 23'h9);
    n_tests++;
    if (rx_ovf !== 1'b1 || rx_drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL ovf_clr_vs_drop: got ovf=%b drop=%0d exp 1/1", rx_ovf, rx_drop_cnt);
    end
    for (int k = 0; k < 260; k++) push(7'h01, 3'h0, 23'h9);
    n_tests++;
    if (rx_drop_cnt !== 8'd255) begin
      n_fail++; $display("FAIL ovf_saturate: got %0d exp 255", rx_drop_cnt);
    end
    pe_rx_flush = 1'b1; rx_ovf_clr = 1'b1; step(); idle();
  endtask

  task automatic test_soft_reset();
    for (int k = 1; k <= 3; k++) push(7'h01, 3'h0, 23'(k));
    pe_rx_ack = 1'b1;
    push(7'h0D, 3'h2, 23'h7);
    n_tests++;
    if ({pe_rx_vld, rx_q_cnt, pe_rx_type, pe_rx_sop_type, pe_rx_info, rx_ovf} !== {1'b1, 3'd1, 7'h0D, 3'h2, 23'h7, 1'b0}) begin
      n_fail++; $display("FAIL soft_reset: got vld=%b cnt=%0d type=%h sop=%h info=%h ovf=%b exp 1/1/0d/2/7/0", pe_rx_vld, rx_q_cnt, pe_rx_type, pe_rx_sop_type, pe_rx_info, rx_ovf);
    end
    ack();
    n_tests++;
    if (pe_rx_vld !== 1'b0) begin
      n_fail++; $display("FAIL soft_reset_ack: got vld=%b exp 0", pe_rx_vld);
    end
  endtask

  task automatic test_count_one();
    push(7'h01, 3'h0, 23'hA);
    pe_rx_ack = 1'b1;
    push(7'h02, 3'h1, 23'hB);
    n_tests++;
    if ({pe_rx_vld, rx_q_cnt, pe_rx_type, pe_rx_info} !== {1'b1, 3'd1, 7'h02, 23'hB}) begin
      n_fail++; $display("FAIL count_one_push_pop: got vld=%b cnt=%0d type=%h info=%h exp 1/1/02/b", pe_rx_vld, rx_q_cnt, pe_rx_type, pe_rx_info);
    end
    ack();
  endtask

  task automatic test_flush();
    push(7'h01, 3'h0, 23'h1);
    push(7'h01, 3'h0, 23'h2);
    pe_rx_flush = 1'b1;
    push(7'h01, 3'h0, 23'h3);
    n_tests++;
    if (pe_rx_vld !== 1'b0 || rx_q_cnt !== 3'd0 || rx_drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL flush: got vld=%b cnt=%0d drop=%0d exp 0/0/0", pe_rx_vld, rx_q_cnt, rx_drop_cnt);
    end
    for (int k = 1; k <= 4; k++) push(7'h01, 3'h0, 23'(k));
    pe_rx_flush = 1'b1;
    push(7'h01, 3'h0, 23'h5);
    n_tests++;
    if (rx_q_cnt !== 3'd0 || rx_ovf !== 1'b0 || rx_drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL flush_full: got cnt=%0d ovf=%b drop=%0d exp 0/0/0", rx_q_cnt, rx_ovf, rx_drop_cnt);
    end
    push(7'h03, 3'h4, 23'h55);
    n_tests++;
    if (pe_rx_vld !== 1'b1 || pe_rx_info !== 23'h55 || rx_q_cnt !== 3'd1) begin
      n_fail++; $display("FAIL flush_then_push: got vld=%b info=%h cnt=%0d exp 1/55/1", pe_rx_vld, pe_rx_info, rx_q_cnt);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    push(7'h01, 3'h5, 23'h111);
    push(7'h01, 3'h5, 23'h222);
    rst = 1'b1; step(); rst = 1'b0;
    n_tests++;
    if ({pe_rx_vld, rx_q_cnt, rx_ovf, rx_drop_cnt, pe_rx_type, pe_rx_sop_type, pe_rx_info} !== 46'h0) begin
      n_fail++; $display("FAIL reset_mid: got vld=%b cnt=%0d head=%h exp 0", pe_rx_vld, rx_q_cnt, {pe_rx_type, pe_rx_sop_type, pe_rx_info});
    end
    ack();
    n_tests++;
    if (pe_rx_vld !== 1'b0 || rx_q_cnt !== 3'd0) begin
      n_fail++; $display("FAIL stray_ack: got vld=%b cnt=%0d exp 0/0", pe_rx_vld, rx_q_cnt);
    end
    push(7'h01, 3'h0, 23'h42);
    n_tests++;
    if (rx_q_cnt !== 3'd1 || pe_rx_info !== 23'h42) begin
      n_fail++; $display("FAIL stray_ack_after: got cnt=%0d info=%h exp 1/42", rx_q_cnt, pe_rx_info);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_burst_wrap();
    test_overflow();
    test_soft_reset();
    test_count_one();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
